// File: rtl/alu_mc_if.sv
// alu_mc_if: operation/result handshake bundle between IDU, execute ALU and LSU/WBU.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_mc_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  alu_ctrl;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] csr_input;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_result;
    logic            illegal_op;

    // Upstream / downstream side (IDU driving ops, consumer accepting results).
    modport master (
        output flush, in_valid, alu_ctrl, src1, src2, csr_input, out_ready,
        input  in_ready, out_valid, alu_result, illegal_op
    );

    // ALU side.
    modport slave (
        input  flush, in_valid, alu_ctrl, src1, src2, csr_input, out_ready,
        output in_ready, out_valid, alu_result, illegal_op
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute ALU, one op in flight; optional iterative MDU when ALU_MDU_EN is defined.
// Latency: base ops 1 cycle after accept; MDU ops XLEN+1 cycles after accept.
// Backpressure: result held until out_ready; in_ready only in IDLE or when DONE result drains this cycle.
module alu_mc #(
    parameter int XLEN = 32,
    parameter int OPW  = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mc_if.slave   bus
);
    localparam int SW = $clog2(XLEN);

    localparam logic [OPW-1:0] OP_ADD   = OPW'('h00);
    localparam logic [OPW-1:0] OP_PASS  = OPW'('h01);
    localparam logic [OPW-1:0] OP_SUB   = OPW'('h02);
    localparam logic [OPW-1:0] OP_JALR  = OPW'('h03);
    localparam logic [OPW-1:0] OP_SLTU  = OPW'('h04);
    localparam logic [OPW-1:0] OP_XOR   = OPW'('h05);
    localparam logic [OPW-1:0] OP_OR    = OPW'('h06);
    localparam logic [OPW-1:0] OP_AND   = OPW'('h07);
    localparam logic [OPW-1:0] OP_SLL   = OPW'('h08);
    localparam logic [OPW-1:0] OP_SRA   = OPW'('h09);
    localparam logic [OPW-1:0] OP_SRL   = OPW'('h0A);
    localparam logic [OPW-1:0] OP_SLT   = OPW'('h0C);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'('h0D);
    localparam logic [OPW-1:0] OP_BGE   = OPW'('h0E);
    localparam logic [OPW-1:0] OP_BGEU  = OPW'('h0F);
    localparam logic [OPW-1:0] OP_BLT   = OPW'('h10);
    localparam logic [OPW-1:0] OP_BLTU  = OPW'('h11);
    localparam logic [OPW-1:0] OP_BNE   = OPW'('h12);
    localparam logic [OPW-1:0] OP_SLL2  = OPW'('h13);
    localparam logic [OPW-1:0] OP_SRA2  = OPW'('h14);
    localparam logic [OPW-1:0] OP_SRL2  = OPW'('h15);
    localparam logic [OPW-1:0] OP_CSRRS = OPW'('h16);
    localparam logic [OPW-1:0] OP_CSRRW = OPW'('h17);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;

    logic            accept;
    logic            is_mdu;
    logic [XLEN-1:0] base_res;
    logic            base_ill;
    logic [SW-1:0]   shamt;

    assign bus.in_ready   = (state == S_IDLE) || ((state == S_DONE) && bus.out_ready);
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.illegal_op = illegal_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign shamt  = bus.src2[SW-1:0];

    // Single-cycle result; anything not decoded here (incl. 01011 and MDU encodings) is flagged illegal.
    always_comb begin
        base_res = '0;
        base_ill = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD:                  base_res = bus.src1 + bus.src2;
            OP_PASS:                 base_res = bus.src2;
            OP_SUB:                  base_res = bus.src1 - bus.src2;
            OP_JALR:                 base_res = (bus.src1 + bus.src2) & ~XLEN'(1);
            OP_SLTU:                 base_res = XLEN'(bus.src1 < bus.src2);
            OP_XOR:                  base_res = bus.src1 ^ bus.src2;
            OP_OR:                   base_res = bus.src1 | bus.src2;
            OP_AND:                  base_res = bus.src1 & bus.src2;
            OP_SLL, OP_SLL2:         base_res = bus.src1 << shamt;
            OP_SRA, OP_SRA2:         base_res = $signed(bus.src1) >>> shamt;
            OP_SRL, OP_SRL2:         base_res = bus.src1 >> shamt;
            OP_SLT:                  base_res = XLEN'($signed(bus.src1) < $signed(bus.src2));
            OP_BEQ:                  base_res = XLEN'(bus.src1 == bus.src2);
            OP_BGE:                  base_res = XLEN'($signed(bus.src1) >= $signed(bus.src2));
            OP_BGEU:                 base_res = XLEN'(bus.src1 >= bus.src2);
            OP_BLT:                  base_res = XLEN'($signed(bus.src1) < $signed(bus.src2));
            OP_BLTU:                 base_res = XLEN'(bus.src1 < bus.src2);
            OP_BNE:                  base_res = XLEN'(bus.src1 != bus.src2);
            OP_CSRRS:                base_res = bus.src1 | bus.csr_input;
            OP_CSRRW:                base_res = bus.src1;
            default:                 base_ill = 1'b1;
        endcase
    end

`ifdef ALU_MDU_EN
    localparam logic [OPW-1:0] OP_MUL = OPW'('h18);

    // Shared iterative datapath: hi/lo hold partial product or remainder/quotient, opnd the |multiplicand|/|divisor|.
    logic [2:0]      md_op_q;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q, s1_q;
    logic            res_neg_q, rem_neg_q, div0_q;
    logic [SW-1:0]   cnt_q;

    logic            sgn1, sgn2, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic [XLEN:0]   sum, rs, diff;
    logic [XLEN-1:0] n_hi, n_lo;
    logic [2*XLEN-1:0] prod, sprod;
    logic [XLEN-1:0] md_res;
    logic            last;

    assign is_mdu = (bus.alu_ctrl >= OP_MUL);
    assign last   = (cnt_q == SW'(XLEN - 1));

    // Operand signedness by op (mul/mulh/div/rem signed; mulhsu signed src1 only) and magnitudes.
    always_comb begin
        sgn1  = bus.alu_ctrl[2] ? !bus.alu_ctrl[0] : (bus.alu_ctrl[1:0] != 2'b11);
        sgn2  = bus.alu_ctrl[2] ? !bus.alu_ctrl[0] : !bus.alu_ctrl[1];
        a_neg = sgn1 && bus.src1[XLEN-1];
        b_neg = sgn2 && bus.src2[XLEN-1];
        a_abs = a_neg ? -bus.src1 : bus.src1;
        b_abs = b_neg ? -bus.src2 : bus.src2;
    end

    // One iteration: shift-add multiply step or restoring divide step.
    always_comb begin
        sum  = '0;
        rs   = '0;
        diff = '0;
        n_hi = hi_q;
        n_lo = lo_q;
        if (!md_op_q[2]) begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
            n_hi = sum[XLEN:1];
            n_lo = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            rs   = {hi_q, lo_q[XLEN-1]};
            diff = rs - {1'b0, opnd_q};
            if (!diff[XLEN]) begin
                n_hi = diff[XLEN-1:0];
                n_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                n_hi = rs[XLEN-1:0];
                n_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    // Final sign fix-up and divide-by-zero override, applied to the last iteration's values.
    always_comb begin
        prod  = {n_hi, n_lo};
        sprod = res_neg_q ? -prod : prod;
        case (md_op_q)
            3'd0:          md_res = sprod[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          md_res = sprod[2*XLEN-1:XLEN];
            3'd4, 3'd5:    md_res = div0_q ? '1 : (res_neg_q ? -n_lo : n_lo);
            default:       md_res = div0_q ? s1_q : (rem_neg_q ? -n_hi : n_hi);
        endcase
    end
`else
    assign is_mdu = 1'b0;
`endif

    // Control FSM with registered outputs; flush aborts everything and beats a same-cycle accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
`ifdef ALU_MDU_EN
            md_op_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            s1_q        <= '0;
            res_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            div0_q      <= 1'b0;
            cnt_q       <= '0;
`endif
        end else if (bus.flush) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
`ifdef ALU_MDU_EN
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state)
                S_BUSY: begin
`ifdef ALU_MDU_EN
                    hi_q  <= n_hi;
                    lo_q  <= n_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= md_res;
                        illegal_q   <= 1'b0;
                    end
`else
                    state <= S_IDLE;
`endif
                end
                default: begin
                    if ((state == S_DONE) && bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                    if (accept) begin
                        if (is_mdu) begin
                            state       <= S_BUSY;
                            out_valid_q <= 1'b0;
`ifdef ALU_MDU_EN
                            md_op_q     <= bus.alu_ctrl[2:0];
                            hi_q        <= '0;
                            lo_q        <= a_abs;
                            opnd_q      <= b_abs;
                            s1_q        <= bus.src1;
                            res_neg_q   <= a_neg ^ b_neg;
                            rem_neg_q   <= a_neg;
                            div0_q      <= (bus.src2 == '0);
                            cnt_q       <= '0;
`endif
                        end else begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= base_ill ? '0 : base_res;
                            illegal_q   <= base_ill;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed-vector bench for alu_mc, one task per scenario.
// Latency: counted in cycles from the accept edge, sampled on the falling edge.
// Backpressure: out_ready stalls, back-to-back streaming and flush/reset aborts exercised.
module tb_alu_mc;
    localparam int XLEN = 32;
    localparam int OPW  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(XLEN), .OPW(OPW)) bus ();

    alu_mc #(.XLEN(XLEN), .OPW(OPW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue one op, scramble inputs after accept, wait (bounded) for the result.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, output logic [31:0] res, output logic ill,
                          output int lat);
        @(negedge clk);
        bus.alu_ctrl  = op;
        bus.src1      = a;
        bus.src2      = b;
        bus.csr_input = c;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 5'b00101;
        bus.src1      = 32'hDEADBEEF;
        bus.src2      = 32'h0BADF00D;
        bus.csr_input = 32'h12345678;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = bus.alu_result;
        ill = bus.illegal_op;
    endtask

    task automatic test_reset();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = '0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.csr_input = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.alu_result !== 32'h0) $display("FAIL reset_result got %h want 00000000", bus.alu_result);
        else pass_cnt++;
        total_cnt++;
        if (bus.illegal_op !== 1'b0) $display("FAIL reset_illegal got %b want 0", bus.illegal_op);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        else pass_cnt++;
    endtask

    task automatic test_base_ops();
        logic [4:0]  ops [16];
        logic [31:0] va  [16];
        logic [31:0] vb  [16];
        logic [31:0] vc  [16];
        logic [31:0] exp [16];
        logic        eil [16];
        logic [31:0] res;
        logic        ill;
        int          lat;
        ops = '{5'h00, 5'h02, 5'h09, 5'h0C, 5'h04, 5'h03, 5'h01, 5'h05,
                5'h07, 5'h13, 5'h15, 5'h0D, 5'h12, 5'h16, 5'h17, 5'h0B};
        va  = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1001, 32'h1234, 32'hF0F0,
                32'hF0F0, 32'h1, 32'h80000000, 32'h5, 32'h5, 32'hF0, 32'hAB, 32'h5};
        vb  = '{32'h1, 32'h1, 32'h24, 32'h1, 32'h1, 32'h10, 32'h5678, 32'hFF00,
                32'hFF00, 32'h4, 32'h1F, 32'h5, 32'h3, 32'h0, 32'h0, 32'h6};
        vc  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0F, 32'h77, 32'h0};
        exp = '{32'h80000000, 32'hFFFFFFFF, 32'hF8000000, 32'h1, 32'h0, 32'h1010, 32'h5678, 32'h0FF0,
                32'hF000, 32'h10, 32'h1, 32'h1, 32'h1, 32'hFF, 32'hAB, 32'h0};
        eil = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) begin
            run_op(ops[i], va[i], vb[i], vc[i], res, ill, lat);
            total_cnt++;
            if (res !== exp[i]) $display("FAIL base[%0d] op=%h result got %h want %h", i, ops[i], res, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (ill !== eil[i]) $display("FAIL base[%0d] op=%h illegal got %b want %b", i, ops[i], ill, eil[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat != 1) $display("FAIL base[%0d] op=%h latency got %0d want 1", i, ops[i], lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.alu_ctrl  = 5'h00;
        bus.src1      = 32'd5;
        bus.src2      = 32'd6;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.src1      = 32'h0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (bus.out_valid !== 1'b1) $display("FAIL stall[%0d] out_valid got %b want 1", i, bus.out_valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.alu_result !== 32'd11) $display("FAIL stall[%0d] result got %h want 0000000b", i, bus.alu_result);
            else pass_cnt++;
            total_cnt++;
            if (bus.in_ready !== 1'b0) $display("FAIL stall[%0d] in_ready got %b want 0", i, bus.in_ready);
            else pass_cnt++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL stall_drain out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = 5'h00;
        bus.src1      = 32'd0;
        bus.src2      = 32'd100;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            total_cnt++;
            if (bus.out_valid !== 1'b1) $display("FAIL b2b[%0d] out_valid got %b want 1", i, bus.out_valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.alu_result !== 32'(100 + i)) $display("FAIL b2b[%0d] result got %h want %h", i, bus.alu_result, 32'(100 + i));
            else pass_cnt++;
            if (i < 3) bus.src1 = 32'(i + 1);
            else bus.in_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic        ill;
        int          lat;
        // Flush a held result.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.alu_ctrl  = 5'h00;
        bus.src1      = 32'd2;
        bus.src2      = 32'd3;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b1) $display("FAIL flush_pre out_valid got %b want 1", bus.out_valid);
        else pass_cnt++;
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL flush_held out_valid got %b want 0", bus.out_valid);
        else pass_cnt++;
        // Flush beats a same-cycle accept.
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.out_valid !== 1'b0) $display("FAIL flush_accept[%0d] out_valid got %b want 0", i, bus.out_valid);
            else pass_cnt++;
            @(negedge clk);
        end
        run_op(5'h00, 32'd1, 32'd2, 32'd0, res, ill, lat);
        total_cnt++;
        if (res !== 32'd3 || lat != 1) $display("FAIL flush_after result got %h lat %0d want 00000003 lat 1", res, lat);
        else pass_cnt++;
    endtask

`ifdef ALU_MDU_EN
    task automatic abort_div(input bit use_reset);
        logic [31:0] res;
        logic        ill;
        int          lat;
        bit          seen;
        @(negedge clk);
        bus.alu_ctrl = 5'h1C;
        bus.src1     = 32'd100;
        bus.src2     = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        if (use_reset) rst_n = 1'b0;
        else bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_div(reset=%0d) stale out_valid got 1 want 0", use_reset);
        else pass_cnt++;
        run_op(5'h00, 32'd10, 32'd20, 32'd0, res, ill, lat);
        total_cnt++;
        if (res !== 32'd30 || lat != 1) $display("FAIL abort_div(reset=%0d) next add got %h lat %0d want 0000001e lat 1", use_reset, res, lat);
        else pass_cnt++;
    endtask

    task automatic test_mdu();
        logic [4:0]  ops [12];
        logic [31:0] va  [12];
        logic [31:0] vb  [12];
        logic [31:0] exp [12];
        logic [31:0] res;
        logic        ill;
        int          lat;
        ops = '{5'h19, 5'h1C, 5'h1E, 5'h1C, 5'h1F, 5'h18, 5'h1D, 5'h1E, 5'h1C, 5'h1B, 5'h1A, 5'h1E};
        va  = '{32'hFFFFFFFE, 32'd7, 32'd7, 32'h80000000, 32'd100, 32'd7, 32'd100, 32'hFFFFFFF9,
                32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        vb  = '{32'd3, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFFD, 32'd7, 32'd2,
                32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        exp = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'hFFFFFFEB, 32'd14, 32'hFFFFFFFF,
                32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
        for (int i = 0; i < 12; i++) begin
            run_op(ops[i], va[i], vb[i], 32'h0, res, ill, lat);
            total_cnt++;
            if (res !== exp[i]) $display("FAIL mdu[%0d] op=%h result got %h want %h", i, ops[i], res, exp[i]);
            else pass_cnt++;
            total_cnt++;
            if (ill !== 1'b0) $display("FAIL mdu[%0d] op=%h illegal got %b want 0", i, ops[i], ill);
            else pass_cnt++;
            total_cnt++;
            if (lat != XLEN + 1) $display("FAIL mdu[%0d] op=%h latency got %0d want %0d", i, ops[i], lat, XLEN + 1);
            else pass_cnt++;
        end
        abort_div(1'b0);
        abort_div(1'b1);
    endtask
`else
    task automatic test_no_mdu();
        logic [31:0] res;
        logic        ill;
        int          lat;
        run_op(5'h18, 32'd3, 32'd4, 32'h0, res, ill, lat);
        total_cnt++;
        if (res !== 32'h0 || ill !== 1'b1 || lat != 1)
            $display("FAIL no_mdu_mul got res=%h ill=%b lat=%0d want 00000000 1 1", res, ill, lat);
        else pass_cnt++;
        run_op(5'h1C, 32'd100, 32'd7, 32'h0, res, ill, lat);
        total_cnt++;
        if (res !== 32'h0 || ill !== 1'b1 || lat != 1)
            $display("FAIL no_mdu_div got res=%h ill=%b lat=%0d want 00000000 1 1", res, ill, lat);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_base_ops();
        test_stall();
        test_back_to_back();
        test_flush();
`ifdef ALU_MDU_EN
        test_mdu();
`else
        test_no_mdu();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
